// File: rtl/fft_power_drain.sv
// fft_power_drain: consumes complex FFT bins from the core's read port,
// computes |X|^2 = re^2 + im^2 in a two-stage pipeline, buffers results in a
// credit-controlled FIFO and presents them on a valid/ready output tagged with
// bin index and a last flag. Signals frame completion with a one-cycle pulse.
//
// Optional feature macro: PEAK_TRACK_EN (tracks bin/value of maximum power).
//
// Ports:
//   clk, Reset                  clock, synchronous active-high reset
//   i_START, i_SAMP_NUMBER      arm a frame with the given bin count (IDLE only)
//   i_RDATA, i_RVALID, o_RREADY input bins {re[31:16], im[15:0]}, signed Q15
//   o_PWR_DATA/BIN/LAST/VALID,
//   i_PWR_READY                 power output stream
//   o_BUSY                      frame in progress
//   o_FRAME_DONE                pulse after the last word leaves
//   o_PEAK_BIN, o_PEAK_PWR      peak tracking result (zero when feature is off)
module fft_power_drain #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned BIN_W = 12
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             i_START,
  input  logic [BIN_W-1:0] i_SAMP_NUMBER,
  input  logic [31:0]      i_RDATA,
  input  logic             i_RVALID,
  output logic             o_RREADY,
  output logic [31:0]      o_PWR_DATA,
  output logic [BIN_W-1:0] o_PWR_BIN,
  output logic             o_PWR_LAST,
  output logic             o_PWR_VALID,
  input  logic             i_PWR_READY,
  output logic             o_BUSY,
  output logic             o_FRAME_DONE,
  output logic [BIN_W-1:0] o_PEAK_BIN,
  output logic [31:0]      o_PEAK_PWR
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_n;

  logic [BIN_W-1:0] count_q;
  logic [BIN_W-1:0] in_cnt;

  // Stage 1: squared components
  logic             s1_valid;
  logic [30:0]      s1_sq_re;
  logic [30:0]      s1_sq_im;
  logic [BIN_W-1:0] s1_bin;
  logic             s1_last;

  // Stage 2: summed power
  logic             s2_valid;
  logic [31:0]      s2_pwr;
  logic [BIN_W-1:0] s2_bin;
  logic             s2_last;

  // FIFO storage behind the output register
  logic [31:0]      mem_pwr  [DEPTH];
  logic [BIN_W-1:0] mem_bin  [DEPTH];
  logic             mem_last [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] mem_cnt;

  logic             accept;
  logic             pop;
  logic             start_ok;
  logic             last_in;
  logic             load_out;
  logic             mem_rd;
  logic             bypass;
  logic             mem_wr;
  logic             out_valid_n;
  logic [CNT_W-1:0] mem_cnt_n;
  logic [OCC_W-1:0] total_n;
  logic             rready_n;
  logic signed [31:0] re_ext;
  logic signed [31:0] im_ext;
  logic [30:0]      sq_re;
  logic [30:0]      sq_im;

  // Next-state, handshakes, FIFO steering and credit computation
  always_comb begin
    state_n     = state;
    accept      = i_RVALID && o_RREADY;
    pop         = o_PWR_VALID && i_PWR_READY;
    start_ok    = (state == IDLE) && i_START && (i_SAMP_NUMBER != '0);
    last_in     = (in_cnt == (count_q - BIN_W'(1)));
    re_ext      = 32'($signed(i_RDATA[31:16]));
    im_ext      = 32'($signed(i_RDATA[15:0]));
    sq_re       = 31'(re_ext * re_ext);
    sq_im       = 31'(im_ext * im_ext);

    // The output register refills from storage first so ordering is kept;
    // a stage-2 word bypasses storage only when storage is empty.
    load_out    = !o_PWR_VALID || pop;
    mem_rd      = load_out && (mem_cnt != '0);
    bypass      = load_out && (mem_cnt == '0) && s2_valid;
    mem_wr      = s2_valid && !bypass;
    out_valid_n = load_out ? (mem_rd || bypass) : 1'b1;
    mem_cnt_n   = mem_cnt + CNT_W'(mem_wr) - CNT_W'(mem_rd);

    case (state)
      IDLE:    if (start_ok) state_n = RUN;
      RUN:     if (accept && last_in) state_n = DRAIN;
      DRAIN:   if (pop && o_PWR_LAST) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Credits: everything stored or in flight next cycle must fit in DEPTH
    total_n  = OCC_W'(mem_cnt_n) + OCC_W'(out_valid_n) + OCC_W'(accept) + OCC_W'(s1_valid);
    rready_n = (state_n == RUN) && (total_n < OCC_W'(DEPTH));
  end

  // State register, frame counters and status outputs
  always_ff @(posedge clk) begin
    if (Reset) begin
      state        <= IDLE;
      count_q      <= '0;
      in_cnt       <= '0;
      o_RREADY     <= 1'b0;
      o_BUSY       <= 1'b0;
      o_FRAME_DONE <= 1'b0;
    end else begin
      state        <= state_n;
      o_RREADY     <= rready_n;
      o_BUSY       <= (state_n != IDLE);
      o_FRAME_DONE <= (state_n == DONE);
      if (start_ok) begin
        count_q <= i_SAMP_NUMBER;
        in_cnt  <= '0;
      end else if (accept) begin
        in_cnt  <= in_cnt + BIN_W'(1);
      end
    end
  end

  // Two-stage power pipeline
  always_ff @(posedge clk) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_sq_re <= '0;
      s1_sq_im <= '0;
      s1_bin   <= '0;
      s1_last  <= 1'b0;
      s2_valid <= 1'b0;
      s2_pwr   <= '0;
      s2_bin   <= '0;
      s2_last  <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_sq_re <= sq_re;
        s1_sq_im <= sq_im;
        s1_bin   <= in_cnt;
        s1_last  <= last_in;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_pwr  <= {1'b0, s1_sq_re} + {1'b0, s1_sq_im};
        s2_bin  <= s1_bin;
        s2_last <= s1_last;
      end
    end
  end

  // FIFO storage array
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem_pwr[wr_ptr]  <= s2_pwr;
      mem_bin[wr_ptr]  <= s2_bin;
      mem_last[wr_ptr] <= s2_last;
    end
  end

  // FIFO pointers and output register
  always_ff @(posedge clk) begin
    if (Reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_cnt     <= '0;
      o_PWR_VALID <= 1'b0;
      o_PWR_DATA  <= '0;
      o_PWR_BIN   <= '0;
      o_PWR_LAST  <= 1'b0;
    end else begin
      mem_cnt     <= mem_cnt_n;
      o_PWR_VALID <= out_valid_n;
      if (mem_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (mem_rd) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        o_PWR_DATA <= mem_pwr[rd_ptr];
        o_PWR_BIN  <= mem_bin[rd_ptr];
        o_PWR_LAST <= mem_last[rd_ptr];
      end else if (bypass) begin
        o_PWR_DATA <= s2_pwr;
        o_PWR_BIN  <= s2_bin;
        o_PWR_LAST <= s2_last;
      end
    end
  end

`ifdef PEAK_TRACK_EN
  // Peak tracker: strict greater-than keeps the lowest bin on ties
  always_ff @(posedge clk) begin
    if (Reset) begin
      o_PEAK_BIN <= '0;
      o_PEAK_PWR <= '0;
    end else if (start_ok) begin
      o_PEAK_BIN <= '0;
      o_PEAK_PWR <= '0;
    end else if (pop && (o_PWR_DATA > o_PEAK_PWR)) begin
      o_PEAK_BIN <= o_PWR_BIN;
      o_PEAK_PWR <= o_PWR_DATA;
    end
  end
`else
  assign o_PEAK_BIN = '0;
  assign o_PEAK_PWR = '0;
`endif

endmodule

// File: doc/fft_power_drain.md
Name: fft_power_drain

Overview:
Downstream consumer of the FFT core's result read port; sits directly after the core's RDATA/RVALID/RREADY interface.
- Accepts one 32-bit complex bin per handshake: real in [31:16], imag in [15:0], both signed Q15.
- Computes the power |X|^2 = re^2 + im^2 in a 2-stage pipeline and buffers results in a small FIFO.
- Presents power words on a valid/ready output, tagged with bin index; counts bins per frame and flags frame completion.

Parameters:
DEPTH, 8, output FIFO entries (power of two, >= 4)
BIN_W, 12, bin-index / sample-count width (matches the core's SAMP_NUMBER width)

Ports:
clk  input  1  clock, all logic on rising edge
Reset  input  1  synchronous reset, active-high
i_START  input  1  arm a new frame; sampled only in IDLE
i_SAMP_NUMBER  input  BIN_W  bins per frame; latched on accepted i_START
i_RDATA  input  32  {re[15:0], im[15:0]} from FFT core
i_RVALID  input  1  i_RDATA valid
o_RREADY  output  1  block can accept a bin this cycle
o_PWR_DATA  output  32  unsigned re^2+im^2
o_PWR_BIN  output  BIN_W  bin index of o_PWR_DATA
o_PWR_LAST  output  1  marks final bin of the frame
o_PWR_VALID  output  1  output word valid
i_PWR_READY  input  1  sink accepts output word
o_BUSY  output  1  state != IDLE
o_FRAME_DONE  output  1  one-cycle pulse when the last bin leaves the FIFO
o_PEAK_BIN  output  BIN_W  bin of maximum power (optional feature)
o_PEAK_PWR  output  32  maximum power value (optional feature)

Behaviour:
- Reset: state=IDLE; FIFO empty; pipeline valids cleared; bin counters=0; o_RREADY=0, o_PWR_VALID=0, o_PWR_DATA=0, o_PWR_BIN=0, o_PWR_LAST=0, o_BUSY=0, o_FRAME_DONE=0, o_PEAK_*=0. Reset mid-frame discards all in-flight data; no o_FRAME_DONE is produced.
- FSM states:
  - IDLE: i_START=1 with i_SAMP_NUMBER!=0 -> RUN; latch count, clear in-counter, out-counter and peak. i_START with count 0 is ignored.
  - RUN: accept bins. When the accepted bin index equals count-1 -> DRAIN.
  - DRAIN: o_RREADY=0. When the last-tagged word handshakes at the output -> DONE.
  - DONE: o_FRAME_DONE=1 for exactly one cycle, then -> IDLE.
- Input acceptance: o_RREADY = (state==RUN) && (FIFO occupancy + pipeline in-flight < DEPTH). This is credit-based, so the FIFO never overflows. Transfer occurs on i_RVALID && o_RREADY. o_RREADY does not combinationally depend on i_RVALID.
- Pipeline:
  - Stage 1 registers signed re*re and im*im (each 31-bit non-negative) plus bin index and last flag.
  - Stage 2 registers the 32-bit unsigned sum and pushes it into the FIFO.
  - Latency from input handshake to o_PWR_VALID is 3 cycles with an empty FIFO and i_PWR_READY=1.
  - Throughput is one bin per cycle.
- Arithmetic: full precision, no rounding or saturation. Max result is (-32768)^2*2 = 0x8000_0000, which fits in 32 bits.
- Output handshake: o_PWR_DATA/BIN/LAST are stable while o_PWR_VALID && !i_PWR_READY. The word is popped on valid&&ready. Simultaneous push and pop is allowed with FIFO full or empty, and occupancy is unchanged.
- Bin index: the input counter wraps only via frame restart, never mid-frame. o_PWR_LAST = (bin == count-1).
- i_START outside IDLE is ignored. i_RVALID outside RUN is ignored (no handshake).

Optional Feature:
PEAK_TRACK_EN
- Defined: at each output handshake, if o_PWR_DATA > o_PEAK_PWR, update o_PEAK_PWR/o_PEAK_BIN. Strict greater-than means ties keep the lowest bin. Both are cleared on frame start and are valid from the o_FRAME_DONE cycle until the next frame start.
- Undefined: o_PEAK_BIN and o_PEAK_PWR are tied to 0 and no comparator logic is generated.

Test Plan:
- Reset, then i_START with count=4, bins re/im = (3,-4),(0,0),(-32768,-32768),(1,1), sink always ready -> o_PWR_DATA 25, 0, 0x8000_0000, 2. Bins 0..3, o_PWR_LAST on bin 3. o_FRAME_DONE one cycle after the last handshake. Peak = bin 2, 0x8000_0000.
- count=16, i_RVALID always 1, i_PWR_READY=0 -> exactly 8 bins accepted, then o_RREADY=0. Release ready -> all 16 words emerge in order with no loss or duplication.
- Random i_RVALID/i_PWR_READY toggling over count=100 -> output sequence matches the reference model, and output data stays stable whenever valid&&!ready.
- i_START with i_SAMP_NUMBER=0 -> stays IDLE, o_BUSY=0. i_START asserted during RUN -> latched count unchanged.
- Reset pulsed after 5 of 10 bins -> all outputs return to reset values next cycle and no o_FRAME_DONE. A new frame with count=2 then completes normally.
- Equal powers (5,0) at bins 1 and 3 with PEAK_TRACK_EN defined -> o_PEAK_BIN=1, o_PEAK_PWR=25.
